core_dmem_responder: RTL and testbench

CORE_DMEM_RESPONDER -- requirements
Module: core_dmem_responder

---
 rtl/core_dmem_responder_if.sv | 23 ++
 rtl/core_dmem_responder.sv | 133 +++++++++++++
 tb/tb_core_dmem_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/core_dmem_responder_if.sv
// Core-side data memory port: MEM-stage request fields plus the responder's
// load data, pipeline stall and bus-error reporting.
interface core_dmem_responder_if;
  logic [31:0] mem_addr_mem;
  logic [31:0] mem_wdata_mem;
  logic        mem_write_mem;
  logic        mem_read_mem;
  logic [2:0]  mem_op_mem;
  logic [31:0] mem_rdata_mem;
  logic        stall_pipl;
  logic        bus_err;
  logic [31:0] err_addr;

  modport master (
    output mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
    input  mem_rdata_mem, stall_pipl, bus_err, err_addr
  );

  modport slave (
    input  mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
    output mem_rdata_mem, stall_pipl, bus_err, err_addr
  );
endinterface

// File: rtl/core_dmem_responder.sv
// Single-port data memory for an in-order core: stores complete in one cycle,
// loads stall the pipeline for exactly one cycle, malformed requests pulse bus_err.
module core_dmem_responder #(
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  core_dmem_responder_if.slave dmem
);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic {IDLE, RD_DATA} state_t;

  state_t      r_state;
  logic [31:0] r_mem [DMEM_DEPTH];
  logic [31:0] r_rd_word;
  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_valid;
  logic        r_bus_err;
  logic [31:0] r_err_addr;

  logic [AW-1:0] w_idx;
  logic          w_idle;
  logic          w_req;
  logic          w_op_ok;
  logic          w_align_ok;
  logic          w_range_ok;
  logic          w_bad;
  logic          w_good_ld;
  logic          w_good_st;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rdata;

  assign w_idx  = dmem.mem_addr_mem[AW+1:2];
  assign w_idle = (r_state == IDLE) && !reset;
  assign w_req  = dmem.mem_read_mem || dmem.mem_write_mem;

  always_comb begin
    w_op_ok = 1'b0;
    case (dmem.mem_op_mem)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_op_ok = 1'b1;
      default:                                w_op_ok = 1'b0;
    endcase
  end

  assign w_align_ok = !((dmem.mem_op_mem[1:0] == 2'b01) && dmem.mem_addr_mem[0]) &&
                      !((dmem.mem_op_mem[1:0] == 2'b10) && (dmem.mem_addr_mem[1:0] != 2'b00));
  assign w_range_ok = ((dmem.mem_addr_mem >> (AW + 2)) == 32'd0);

  assign w_bad     = w_idle && w_req && ((dmem.mem_read_mem && dmem.mem_write_mem) ||
                     !w_op_ok || !w_align_ok || !w_range_ok);
  assign w_good_ld = w_idle && dmem.mem_read_mem && !dmem.mem_write_mem &&
                     w_op_ok && w_align_ok && w_range_ok;
  assign w_good_st = w_idle && dmem.mem_write_mem && !dmem.mem_read_mem &&
                     w_op_ok && w_align_ok && w_range_ok;

  // Store data is replicated across lanes so each byte enable just picks its slot.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign w_be[gi] = w_good_st &&
                        ((dmem.mem_op_mem[1:0] == 2'b10) ||
                         ((dmem.mem_op_mem[1:0] == 2'b01) && (dmem.mem_addr_mem[1] == LANE[1])) ||
                         ((dmem.mem_op_mem[1:0] == 2'b00) && (dmem.mem_addr_mem[1:0] == LANE)));
      assign w_wdata[gi*8 +: 8] =
          (dmem.mem_op_mem[1:0] == 2'b10) ? dmem.mem_wdata_mem[gi*8 +: 8] :
          (dmem.mem_op_mem[1:0] == 2'b01) ? dmem.mem_wdata_mem[(gi%2)*8 +: 8] :
                                            dmem.mem_wdata_mem[7:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
    end
    if (w_good_ld) r_rd_word <= r_mem[w_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op       <= 3'b000;
      r_lane     <= 2'b00;
      r_valid    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_err_addr <= 32'd0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_good_ld) begin
            r_state <= RD_DATA;
            r_op    <= dmem.mem_op_mem;
            r_lane  <= dmem.mem_addr_mem[1:0];
            r_valid <= 1'b1;
          end else if (w_bad) begin
            r_bus_err  <= 1'b1;
            r_err_addr <= dmem.mem_addr_mem;
            if (dmem.mem_read_mem) r_valid <= 1'b0;
          end
        end
        RD_DATA: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load data is a pure function of registers captured at the last good load.
  assign w_byte = r_rd_word[r_lane*8 +: 8];
  assign w_half = r_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  always_comb begin
    w_rdata = 32'd0;
    if (r_valid) begin
      case (r_op)
        3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
        3'b100:  w_rdata = {24'd0, w_byte};
        3'b101:  w_rdata = {16'd0, w_half};
        default: w_rdata = r_rd_word;
      endcase
    end
  end

  assign dmem.mem_rdata_mem = w_rdata;
  assign dmem.stall_pipl    = w_good_ld;
  assign dmem.bus_err       = r_bus_err;
  assign dmem.err_addr      = r_err_addr;
endmodule

// File: tb/tb_core_dmem_responder.sv
// Directed-vector bench for core_dmem_responder: stores, extended loads,
// bad-request reporting, back-to-back loads and reset during a load.
module tb_core_dmem_responder;
  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n_stall;

  core_dmem_responder_if bus_if ();

  core_dmem_responder #(.DMEM_DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .dmem  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d);
    bus_if.mem_read_mem  = rd;
    bus_if.mem_write_mem = wr;
    bus_if.mem_op_mem    = op;
    bus_if.mem_addr_mem  = a;
    bus_if.mem_wdata_mem = d;
  endtask

  // All transaction tasks start and end 1 time unit after a rising edge.
  task automatic do_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, op, a, d);
    @(negedge clk);
    chk("store_stall", {31'd0, bus_if.stall_pipl}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_W, 32'd0, 32'd0);
    $display("store op=%0d addr=0x%08h data=0x%08h", op, a, d);
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, op, a, 32'd0);
    @(negedge clk);
    chk("load_stall_on", {31'd0, bus_if.stall_pipl}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_stall_off", {31'd0, bus_if.stall_pipl}, 32'd0);
    chk("load_rdata", bus_if.mem_rdata_mem, exp);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_W, 32'd0, 32'd0);
    $display("load  op=%0d addr=0x%08h rdata=0x%08h exp=0x%08h", op, a, bus_if.mem_rdata_mem, exp);
  endtask

  task automatic do_bad(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] d);
    drive(rd, wr, op, a, d);
    @(negedge clk);
    chk("bad_no_stall", {31'd0, bus_if.stall_pipl}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_W, 32'd0, 32'd0);
    @(negedge clk);
    chk("bad_err_pulse", {31'd0, bus_if.bus_err}, 32'd1);
    chk("bad_err_addr", bus_if.err_addr, a);
    if (rd) chk("bad_rdata_zero", bus_if.mem_rdata_mem, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bad_err_clear", {31'd0, bus_if.bus_err}, 32'd0);
    @(posedge clk); #1;
    $display("bad   rd=%0b wr=%0b op=%0d addr=0x%08h err_addr=0x%08h", rd, wr, op, a, bus_if.err_addr);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, OP_W, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, bus_if.stall_pipl}, 32'd0);
    chk("rst_rdata", bus_if.mem_rdata_mem, 32'd0);
    chk("rst_bus_err", {31'd0, bus_if.bus_err}, 32'd0);
    chk("rst_err_addr", bus_if.err_addr, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Word store then load
    do_store(OP_W, 32'h10, 32'hDEADBEEF);
    do_load(OP_W, 32'h10, 32'hDEADBEEF);

    // Byte store into a zeroed word
    do_store(OP_W, 32'h20, 32'h0);
    do_store(OP_B, 32'h21, 32'h80);
    do_load(OP_B, 32'h21, 32'hFFFFFF80);
    do_load(OP_BU, 32'h21, 32'h00000080);
    do_load(OP_W, 32'h20, 32'h00008000);

    // Halfword store into the upper half
    do_store(OP_W, 32'h30, 32'h1234ABCD);
    do_store(OP_H, 32'h32, 32'h8001);
    do_load(OP_H, 32'h32, 32'hFFFF8001);
    do_load(OP_HU, 32'h32, 32'h00008001);
    do_load(OP_W, 32'h30, 32'h8001ABCD);

    // Stores and idle cycles leave load data alone
    do_store(OP_W, 32'h0, 32'h11111111);
    do_load(OP_W, 32'h0, 32'h11111111);
    do_store(OP_W, 32'h0, 32'h22222222);
    @(negedge clk);
    chk("idle_rdata_hold", bus_if.mem_rdata_mem, 32'h11111111);
    chk("idle_stall", {31'd0, bus_if.stall_pipl}, 32'd0);
    chk("idle_bus_err", {31'd0, bus_if.bus_err}, 32'd0);
    @(posedge clk); #1;
    $display("idle  rdata=0x%08h", bus_if.mem_rdata_mem);

    // Bad requests
    do_bad(1'b1, 1'b0, OP_W, 32'h6, 32'd0);
    do_bad(1'b0, 1'b1, OP_W, 32'h1000, 32'h55);
    do_load(OP_W, 32'h0, 32'h22222222);
    do_bad(1'b1, 1'b0, OP_H, 32'h33, 32'd0);
    do_bad(1'b1, 1'b0, 3'b011, 32'h8, 32'd0);
    do_bad(1'b1, 1'b1, OP_W, 32'h4, 32'h77);
    do_bad(1'b0, 1'b1, OP_H, 32'h41, 32'hBEEF);

    // Three back-to-back word loads, then a store right after RD_DATA
    do_store(OP_W, 32'h40, 32'h11223344);
    do_store(OP_W, 32'h44, 32'h55667788);
    do_store(OP_W, 32'h48, 32'h99AABBCC);
    n_stall = 0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_word;
      exp_word = (k == 0) ? 32'h11223344 : (k == 1) ? 32'h55667788 : 32'h99AABBCC;
      drive(1'b1, 1'b0, OP_W, 32'h40 + 32'(4*k), 32'd0);
      @(negedge clk);
      if (bus_if.stall_pipl) n_stall++;
      @(posedge clk); #1;
      @(negedge clk);
      if (bus_if.stall_pipl) n_stall++;
      chk("b2b_rdata", bus_if.mem_rdata_mem, exp_word);
      @(posedge clk); #1;
      $display("b2b   load %0d rdata=0x%08h", k, bus_if.mem_rdata_mem);
    end
    chk("b2b_stall_count", 32'(n_stall), 32'd3);
    do_store(OP_W, 32'h44, 32'hCAFEF00D);
    do_load(OP_W, 32'h44, 32'hCAFEF00D);

    // Reset during RD_DATA aborts the load; held request is then reissued
    drive(1'b1, 1'b0, OP_W, 32'h10, 32'd0);
    @(negedge clk);
    chk("rst_load_stall", {31'd0, bus_if.stall_pipl}, 32'd1);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("rst_abort_stall", {31'd0, bus_if.stall_pipl}, 32'd0);
    chk("rst_abort_rdata", bus_if.mem_rdata_mem, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_reissue_stall", {31'd0, bus_if.stall_pipl}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_reissue_off", {31'd0, bus_if.stall_pipl}, 32'd0);
    chk("rst_reissue_rdata", bus_if.mem_rdata_mem, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_W, 32'd0, 32'd0);
    $display("reset-abort reload rdata=0x%08h", bus_if.mem_rdata_mem);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
